// File: rtl/bcd_counter_n_pkg.sv
// ---------------------------------------------------------------------------
// bcd_counter_n_pkg
//   Shared BCD constants and helpers for the cascaded decade counter.
//   Contents:
//     DIGIT_W            width of one packed BCD digit
//     BCD_MAX / BCD_MIN  legal digit range (9 / 0)
//     bcd_nibble_valid   1 when a nibble is a legal decimal digit
//     bcd_sanitize       legal nibble passes through, illegal one becomes 0
// ---------------------------------------------------------------------------
package bcd_counter_n_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic bcd_nibble_valid(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
    return bcd_nibble_valid(nib) ? nib : BCD_MIN;
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//   One registered BCD decade with clear, parallel load and up/down step.
//   Priority inside the decade: reset > clear > load > step.
//   Ports:
//     clock    rising-edge clock
//     reset    synchronous active-high reset (digit -> 0)
//     step     advance this decade one position this cycle
//     up_down  1 = increment, 0 = decrement
//     load     parallel load of value (illegal nibble stored as 0)
//     value    load nibble
//     clear    synchronous clear to 0
//     digit    registered decade value, always 0..9
//     at_max   digit == 9 (carry condition for the next decade)
//     at_min   digit == 0 (borrow condition for the next decade)
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd_counter_n_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  logic [3:0] digit_d;
  logic [3:0] digit_q;

  // Next-digit selection. The >= / > comparisons keep the decade inside
  // 0..9 even if the register were ever disturbed into an illegal code.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = bcd_sanitize(value);
    end else if (step) begin
      if (up_down) begin
        digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : (digit_q + 4'd1);
      end else if (digit_q == BCD_MIN) begin
        digit_d = BCD_MAX;
      end else if (digit_q > BCD_MAX) begin
        digit_d = BCD_MAX;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
//   Cascaded DIGITS-decade BCD up/down counter with clear, parallel load,
//   optional saturation at the terminal value and a load-error flag.
//   Priority: reset > clear > load > enable.
//   Parameters:
//     DIGITS    number of decades (1..8)
//     SATURATE  0 = wrap modulo 10^DIGITS, 1 = hold at all-9s / all-0s
//   Ports:
//     clock       rising-edge clock
//     reset       synchronous active-high reset
//     enable      count this cycle
//     up_down     1 = increment, 0 = decrement
//     clear       synchronous clear to zero
//     load        parallel-load strobe
//     load_value  packed BCD load data, digit 0 in [3:0]
//     counter     registered packed BCD count, digit 0 in [3:0]
//     terminal    combinational: enable and counter at all-9s (up) / all-0s (down)
//     load_error  registered one-cycle flag after a load with an illegal nibble
// ---------------------------------------------------------------------------
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      clear,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  output logic [DIGIT_W*DIGITS-1:0] counter,
  output logic                      terminal,
  output logic                      load_error
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] nib_invalid;

  logic at_terminal;
  logic hold;
  logic count_en;

  logic load_error_d;
  logic load_error_q;

  // Whole-counter terminal condition for the currently selected direction.
  assign at_terminal = up_down ? (&at_max) : (&at_min);
  assign terminal    = enable & at_terminal;

  // In saturating mode the terminal value blocks the step at its root, so
  // no decade moves and the count holds.
  assign hold     = SATURATE & at_terminal;
  assign count_en = enable & ~hold;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    // Combinational carry/borrow chain: decade i steps when every lower
    // decade is at its limit, so all decades update on the same edge.
    if (i == 0) begin : g_root
      assign step[i] = count_en;
    end else begin : g_chain
      assign step[i] = step[i-1] & (up_down ? at_max[i-1] : at_min[i-1]);
    end

    assign nib_invalid[i] = ~bcd_nibble_valid(load_value[i*DIGIT_W +: DIGIT_W]);

    bcd_digit u_digit (
      .clock   (clock),
      .reset   (reset),
      .step    (step[i]),
      .up_down (up_down),
      .load    (load),
      .value   (load_value[i*DIGIT_W +: DIGIT_W]),
      .clear   (clear),
      .digit   (counter[i*DIGIT_W +: DIGIT_W]),
      .at_max  (at_max[i]),
      .at_min  (at_min[i])
    );
  end

  // A load masked by clear is not performed, so it cannot raise the flag.
  always_comb begin
    load_error_d = 1'b0;
    if (load && !clear) begin
      load_error_d = |nib_invalid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_error_q <= 1'b0;
    end else begin
      load_error_q <= load_error_d;
    end
  end

  assign load_error = load_error_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic        rst;
    logic        clr;
    logic        ld;
    logic        en;
    logic        ud;
    logic [11:0] lv;
    logic [11:0] cnt0;
    logic [11:0] cnt1;
    logic        t0;
    logic        t1;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        up_down = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_value = 12'h000;
  logic [11:0] counter0, counter1;
  logic        term0, term1;
  logic        err0, err1;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t tbl[29];

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b0)) dut_wrap (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .counter    (counter0),
    .terminal   (term0),
    .load_error (err0)
  );

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b1)) dut_sat (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .counter    (counter1),
    .terminal   (term1),
    .load_error (err1)
  );

  function automatic logic [11:0] to_bcd(input int n);
    logic [3:0] d0, d1, d2;
    d0 = 4'(n % 10);
    d1 = 4'((n / 10) % 10);
    d2 = 4'((n / 100) % 10);
    return {d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic r, c, l, e, u,
                              input logic [11:0] lv, c0, c1,
                              input logic t0, t1, er);
    vec_t v;
    v.rst = r; v.clr = c; v.ld = l; v.en = e; v.ud = u;
    v.lv = lv; v.cnt0 = c0; v.cnt1 = c1;
    v.t0 = t0; v.t1 = t1; v.err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Apply inputs mid-cycle; terminal can be sampled right after this.
  task automatic drive(input logic r, c, l, e, u, input logic [11:0] lv);
    @(negedge clk);
    reset = r; clear = c; load = l; enable = e; up_down = u; load_value = lv;
    #1;
  endtask

  // Let the rising edge happen and settle before sampling registers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(H,L,L,H,H,12'h000, 12'h000,12'h000, H,L,L);
    tbl[1]  = mk(L,L,H,L,H,12'h998, 12'h998,12'h998, L,L,L);
    tbl[2]  = mk(L,L,L,H,H,12'h000, 12'h999,12'h999, L,L,L);
    tbl[3]  = mk(L,L,L,H,H,12'h000, 12'h000,12'h999, H,H,L);
    tbl[4]  = mk(L,L,L,H,H,12'h000, 12'h001,12'h999, L,H,L);
    tbl[5]  = mk(L,L,L,H,H,12'h000, 12'h002,12'h999, L,H,L);
    tbl[6]  = mk(L,L,L,H,L,12'h000, 12'h001,12'h998, L,L,L);
    tbl[7]  = mk(L,L,H,L,H,12'h1A7, 12'h107,12'h107, L,L,H);
    tbl[8]  = mk(L,L,L,L,H,12'h000, 12'h107,12'h107, L,L,L);
    tbl[9]  = mk(L,L,L,L,L,12'h000, 12'h107,12'h107, L,L,L);
    tbl[10] = mk(H,H,H,H,H,12'h555, 12'h000,12'h000, L,L,L);
    tbl[11] = mk(L,H,H,L,H,12'h555, 12'h000,12'h000, L,L,L);
    tbl[12] = mk(L,L,H,L,H,12'h555, 12'h555,12'h555, L,L,L);
    tbl[13] = mk(L,H,L,L,H,12'h000, 12'h000,12'h000, L,L,L);
    tbl[14] = mk(L,H,H,L,H,12'hFFF, 12'h000,12'h000, L,L,L);
    tbl[15] = mk(L,L,H,L,H,12'hF9A, 12'h090,12'h090, L,L,H);
    tbl[16] = mk(L,L,H,L,H,12'h049, 12'h049,12'h049, L,L,L);
    tbl[17] = mk(L,L,L,H,H,12'h000, 12'h050,12'h050, L,L,L);
    tbl[18] = mk(L,L,L,L,L,12'h000, 12'h050,12'h050, L,L,L);
    tbl[19] = mk(L,L,L,H,L,12'h000, 12'h049,12'h049, L,L,L);
    tbl[20] = mk(L,L,L,L,H,12'h000, 12'h049,12'h049, L,L,L);
    tbl[21] = mk(L,L,L,H,H,12'h000, 12'h050,12'h050, L,L,L);
    tbl[22] = mk(L,L,L,H,L,12'h000, 12'h049,12'h049, L,L,L);
    tbl[23] = mk(L,L,L,H,L,12'h000, 12'h048,12'h048, L,L,L);
    tbl[24] = mk(L,H,L,L,L,12'h000, 12'h000,12'h000, L,L,L);
    tbl[25] = mk(L,L,L,H,L,12'h000, 12'h999,12'h000, H,H,L);
    tbl[26] = mk(L,L,L,L,L,12'h000, 12'h999,12'h000, L,L,L);
    tbl[27] = mk(L,L,L,H,H,12'h000, 12'h000,12'h001, H,L,L);
    tbl[28] = mk(L,L,H,H,H,12'h123, 12'h123,12'h123, L,L,L);

    // Reset state.
    drive(H,L,L,L,H,12'h000);
    tick();
    check("reset_cnt_wrap", 32'(counter0), 32'h000);
    check("reset_cnt_sat",  32'(counter1), 32'h000);
    check("reset_err",      32'(err0),     32'h0);
    check("reset_term_idle", 32'(term0),   32'h0);

    // Full up-count sweep 000..999 and back to 000.
    for (int i = 0; i < 1000; i++) begin
      drive(L,L,L,H,H,12'h000);
      check($sformatf("up_term_%0d", i), 32'(term0), 32'(i == 999));
      tick();
      check($sformatf("up_cnt_%0d", i), 32'(counter0), 32'(to_bcd((i + 1) % 1000)));
      check($sformatf("up_sat_%0d", i), 32'(counter1), 32'(to_bcd((i + 1 > 999) ? 999 : i + 1)));
    end

    // Load 100, then count down through 000 into the wrap.
    drive(L,L,H,L,H,12'h100);
    tick();
    check("ld100_cnt", 32'(counter0), 32'h100);
    check("ld100_err", 32'(err0), 32'h0);
    drive(L,L,L,H,L,12'h000);
    tick();
    check("dn_first", 32'(counter0), 32'h099);
    for (int j = 0; j < 100; j++) begin
      int v;
      v = 99 - j;
      drive(L,L,L,H,L,12'h000);
      check($sformatf("dn_term_%0d", v), 32'(term0), 32'(v == 0));
      tick();
      check($sformatf("dn_cnt_%0d", v), 32'(counter0), 32'(to_bcd((v == 0) ? 999 : v - 1)));
      check($sformatf("dn_sat_%0d", v), 32'(counter1), 32'(to_bcd((v == 0) ? 0 : v - 1)));
    end

    // Directed corner-case vectors.
    for (int k = 0; k < 29; k++) begin
      drive(tbl[k].rst, tbl[k].clr, tbl[k].ld, tbl[k].en, tbl[k].ud, tbl[k].lv);
      check($sformatf("vec%0d_term_wrap", k), 32'(term0), 32'(tbl[k].t0));
      check($sformatf("vec%0d_term_sat", k),  32'(term1), 32'(tbl[k].t1));
      tick();
      check($sformatf("vec%0d_cnt_wrap", k), 32'(counter0), 32'(tbl[k].cnt0));
      check($sformatf("vec%0d_cnt_sat", k),  32'(counter1), 32'(tbl[k].cnt1));
      check($sformatf("vec%0d_err_wrap", k), 32'(err0), 32'(tbl[k].err));
      check($sformatf("vec%0d_err_sat", k),  32'(err1), 32'(tbl[k].err));
    end

    // Reset in the middle of a count wins over enable and restarts at 0.
    drive(L,L,L,H,H,12'h000);
    tick();
    check("mid_pre", 32'(counter0), 32'h124);
    drive(H,L,L,H,H,12'h000);
    tick();
    check("mid_reset", 32'(counter0), 32'h000);
    drive(L,L,L,H,H,12'h000);
    tick();
    check("mid_restart", 32'(counter0), 32'h001);

    drive(L,L,L,L,H,12'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of cascaded BCD decades (legal range 1..8).
REQ-002 Parameter SATURATE, default 0, SHALL select the terminal behaviour: 0 = wrap modulo 10^DIGITS; 1 = hold at terminal value.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 enable  input  1  SHALL be the count enable; 1 = count this cycle.
REQ-006 up_down  input  1  SHALL be the direction select: 1 = increment, 0 = decrement.
REQ-007 clear  input  1  SHALL be the synchronous clear to zero.
REQ-008 load  input  1  SHALL be the parallel-load strobe.
REQ-009 load_value  input  4*DIGITS  SHALL be the packed BCD load data, digit 0 in bits [3:0].
REQ-010 counter  output  4*DIGITS  SHALL be the registered packed BCD count, digit 0 least significant.
REQ-011 terminal  output  1  SHALL be combinational: high when enable=1 and counter is all 9s (up) or all 0s (down).
REQ-012 load_error  output  1  SHALL be a registered one-cycle flag for a rejected load nibble.

Function
REQ-013 Priority SHALL be reset > clear > load > enable; lower-priority actions in the same cycle SHALL be ignored.
REQ-014 The counter SHALL change only on the rising edge after the enabling input is sampled (latency 1 cycle); with enable=0, clear=0 and load=0 it SHALL hold.
REQ-015 Up count: digit 0 SHALL step 0..9; at 9 it SHALL return to 0 and carry into digit 1; a digit SHALL step only when every lower digit is 9.
REQ-016 Down count: digit 0 SHALL step 9..0; at 0 it SHALL return to 9 and borrow from digit 1; a digit SHALL step only when every lower digit is 0.
REQ-017 SATURATE=0: all-9s up SHALL wrap to all-0s; all-0s down SHALL wrap to all-9s.
REQ-018 SATURATE=1: all-9s up and all-0s down SHALL hold; terminal SHALL still assert.
REQ-019 The carry/borrow chain SHALL be combinational, so all digits update on the same edge (no ripple latency).
REQ-020 Load: each valid nibble (0..9) SHALL be stored as given; each nibble 10..15 SHALL be stored as 0, and load_error SHALL be 1 for the following cycle.
REQ-021 load_error SHALL be 0 in every cycle that did not follow a load with an invalid nibble.
REQ-022 A counter digit SHALL never hold a value above 9.
REQ-023 A change of up_down SHALL take effect on the next enabled edge with no extra cycle.

Reset
REQ-024 On reset=1 at a rising edge: counter SHALL be 0, load_error SHALL be 0, and terminal SHALL follow from the reset state.
REQ-025 Reset mid-count, or in the same cycle as load, clear or enable, SHALL win, and the next cycle SHALL start from 0.

Structure
REQ-026 A shared package SHALL hold the BCD constants (BCD_MAX = 9, BCD_MIN = 0, digit width 4) and the nibble-validity function.
REQ-027 One sub-module bcd_digit SHALL implement a single decade: inputs step, up_down, load, value, clear; outputs digit, at_max, at_min.
REQ-028 The top level SHALL generate DIGITS instances of bcd_digit and build the carry/borrow chain and the saturation gating.

Verification
REQ-029 DIGITS=3, SATURATE=0: reset, then 1000 enabled up cycles -> counter goes 000..999, back to 000, terminal high exactly at 999.
REQ-030 DIGITS=3: load 0x100, down one cycle -> counter 099; down 100 more cycles -> counter 999 (wrap), terminal high at 000.
REQ-031 DIGITS=3, SATURATE=1: load 0x998, up 3 cycles -> 999, 999, 999; down 1 cycle -> 998.
REQ-032 Load 0x1A7 -> counter 107, load_error high for exactly one cycle, then low.
REQ-033 Reset, clear, load 0x555 and enable all high in one cycle -> counter 000; then clear and load together -> counter 000; then load alone -> counter 555.
REQ-034 Counting at 049 with enable toggling every cycle and up_down flipped -> counter changes only on enabled edges, with the direction of that cycle and no extra latency.
